// File: rtl/ccff_bitstream_loader.sv
// Serializes CHAIN_LEN bitstream bits MSB-first onto ccff_head with a per-bit shift enable, holding IOs isolated until the chain has settled.
// Bits reach the chain one cycle after the word is accepted; bs_ready opens only when the shift register is about to run dry.
module ccff_bitstream_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 64,
   parameter int ISO_HOLD  = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              start,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   output logic              ccff_en,
   output logic              isol_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int RW = $clog2(CHAIN_LEN + 1);
   localparam int HW = $clog2(ISO_HOLD + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int BW = $clog2(WORD_W + 1);
   localparam int CW = (RW > BW) ? RW : BW;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_q;
   logic [WORD_W-1:0] shreg_q;
   logic [BW-1:0]     bit_left_q;
   logic [RW-1:0]     rem_q;
   logic [HW-1:0]     hold_q;
   logic [TW-1:0]     stall_q;
   logic              isol_q;

   logic              shift;
   logic              accept;
   logic              starved;
   logic [RW-1:0]     rem_avail;
   logic [BW-1:0]     fill_len;

   assign shift     = (state_q == S_LOAD) && (bit_left_q != '0);
   assign bs_ready  = (state_q == S_LOAD) && (bit_left_q <= BW'(1))
                      && (CW'(rem_q) > CW'(bit_left_q));
   assign accept    = bs_ready && bs_valid;
   assign starved   = (state_q == S_LOAD) && (bit_left_q == '0) && !bs_valid;

   // Bits of the incoming word past the end of the chain are never counted, so they are never shifted.
   assign rem_avail = rem_q - RW'(bit_left_q);
   assign fill_len  = (32'(rem_avail) >= WORD_W) ? BW'(WORD_W) : BW'(rem_avail);

   assign ccff_en   = shift;
   assign ccff_head = shift & shreg_q[WORD_W-1];
   assign isol_n    = isol_q;
   assign busy      = (state_q == S_LOAD) || (state_q == S_HOLD);
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         state_q    <= S_IDLE;
         shreg_q    <= '0;
         bit_left_q <= '0;
         rem_q      <= '0;
         hold_q     <= '0;
         stall_q    <= '0;
         isol_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_ERR: begin
               if (start) begin
                  state_q    <= S_LOAD;
                  rem_q      <= RW'(CHAIN_LEN);
                  bit_left_q <= '0;
                  hold_q     <= '0;
                  stall_q    <= '0;
                  isol_q     <= 1'b0;
               end
            end
            S_LOAD: begin
               if (shift) begin
                  shreg_q    <= shreg_q << 1;
                  bit_left_q <= bit_left_q - BW'(1);
                  rem_q      <= rem_q - RW'(1);
               end
               // A word accepted while the last buffered bit leaves overrides the shift.
               if (accept) begin
                  shreg_q    <= bs_data;
                  bit_left_q <= fill_len;
                  stall_q    <= '0;
               end else if (starved) begin
                  stall_q    <= stall_q + TW'(1);
               end
               if (shift && (rem_q == RW'(1))) begin
                  state_q <= S_HOLD;
                  hold_q  <= '0;
               end else if (starved && (stall_q == TW'(TIMEOUT - 1))) begin
                  state_q <= S_ERR;
               end
            end
            S_HOLD: begin
               if (hold_q == HW'(ISO_HOLD - 1)) begin
                  state_q <= S_DONE;
                  isol_q  <= 1'b1;
               end else begin
                  hold_q <= hold_q + HW'(1);
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 12-bit chain (A) and a 16-bit chain with short timeout (B),
// expected chain bits queued as words are offered and popped on each ccff_en.
module tb_ccff_bitstream_loader;

   logic prog_clk = 1'b0;
   logic pReset_n = 1'b1;

   logic       start_a = 1'b0, bs_valid_a = 1'b0;
   logic [7:0] bs_data_a = 8'h00;
   logic       bs_ready_a, ccff_head_a, ccff_en_a, isol_n_a, busy_a, done_a, err_a;

   logic       start_b = 1'b0, bs_valid_b = 1'b0;
   logic [7:0] bs_data_b = 8'h00;
   logic       bs_ready_b, ccff_head_b, ccff_en_b, isol_n_b, busy_b, done_b, err_b;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   bit q_a[$];
   bit q_b[$];
   bit exp_a, exp_b;
   int en_cnt_a = 0, en_first_a = 0, en_last_a = 0;
   int en_cnt_b = 0, en_first_b = 0, en_last_b = 0;

   ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(12), .ISO_HOLD(4), .TIMEOUT(8)) dut_a (
      .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start_a),
      .bs_data(bs_data_a), .bs_valid(bs_valid_a), .bs_ready(bs_ready_a),
      .ccff_head(ccff_head_a), .ccff_en(ccff_en_a), .isol_n(isol_n_a),
      .busy(busy_a), .done(done_a), .err(err_a)
   );

   ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(16), .ISO_HOLD(4), .TIMEOUT(3)) dut_b (
      .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start_b),
      .bs_data(bs_data_b), .bs_valid(bs_valid_b), .bs_ready(bs_ready_b),
      .ccff_head(ccff_head_b), .ccff_en(ccff_en_b), .isol_n(isol_n_b),
      .busy(busy_b), .done(done_b), .err(err_b)
   );

   always #5 prog_clk = ~prog_clk;
   always @(posedge prog_clk) cyc <= cyc + 1;

   always @(negedge prog_clk) begin
      n_cmp++;
      if (ccff_en_a) begin
         if (en_cnt_a == 0) en_first_a = cyc;
         en_last_a = cyc;
         en_cnt_a++;
         if (q_a.size() == 0) begin
            n_bad++;
            $display("FAIL head_a: ccff_en at cycle %0d, got bit %0b, want no shift", cyc, ccff_head_a);
         end else begin
            exp_a = q_a.pop_front();
            if (ccff_head_a !== exp_a) begin
               n_bad++;
               $display("FAIL head_a: cycle %0d got %0b want %0b", cyc, ccff_head_a, exp_a);
            end
         end
      end else if (ccff_head_a !== 1'b0) begin
         n_bad++;
         $display("FAIL head_a_idle: cycle %0d got %0b want 0", cyc, ccff_head_a);
      end
   end

   always @(negedge prog_clk) begin
      n_cmp++;
      if (ccff_en_b) begin
         if (en_cnt_b == 0) en_first_b = cyc;
         en_last_b = cyc;
         en_cnt_b++;
         if (q_b.size() == 0) begin
            n_bad++;
            $display("FAIL head_b: ccff_en at cycle %0d, got bit %0b, want no shift", cyc, ccff_head_b);
         end else begin
            exp_b = q_b.pop_front();
            if (ccff_head_b !== exp_b) begin
               n_bad++;
               $display("FAIL head_b: cycle %0d got %0b want %0b", cyc, ccff_head_b, exp_b);
            end
         end
      end else if (ccff_head_b !== 1'b0) begin
         n_bad++;
         $display("FAIL head_b_idle: cycle %0d got %0b want 0", cyc, ccff_head_b);
      end
   end

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   // Offer a word, queue the nbits of it that must reach the chain, return the accept cycle (-1 if never).
   task automatic send_a(input logic [7:0] w, input int nbits, output int acc);
      acc = -1;
      bs_data_a = w;
      bs_valid_a = 1'b1;
      for (int i = 0; i < nbits; i++) q_a.push_back(w[7-i]);
      for (int t = 0; t < 200; t++) begin
         @(negedge prog_clk);
         if (bs_ready_a) begin
            acc = cyc;
            break;
         end
      end
      tick();
      bs_valid_a = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] w, input int nbits, output int acc);
      acc = -1;
      bs_data_b = w;
      bs_valid_b = 1'b1;
      for (int i = 0; i < nbits; i++) q_b.push_back(w[7-i]);
      for (int t = 0; t < 200; t++) begin
         @(negedge prog_clk);
         if (bs_ready_b) begin
            acc = cyc;
            break;
         end
      end
      tick();
      bs_valid_b = 1'b0;
   endtask

   task automatic wait_done_a(output int c, output logic iso);
      c = -1;
      iso = 1'bx;
      for (int t = 0; t < 200; t++) begin
         @(negedge prog_clk);
         if (done_a) begin
            c = cyc;
            iso = isol_n_a;
            break;
         end
      end
      tick();
   endtask

   task automatic wait_done_b(output int c, output logic iso);
      c = -1;
      iso = 1'bx;
      for (int t = 0; t < 200; t++) begin
         @(negedge prog_clk);
         if (done_b) begin
            c = cyc;
            iso = isol_n_b;
            break;
         end
      end
      tick();
   endtask

   task automatic test_reset();
      #1 pReset_n = 1'b0;
      #2;
      n_cmp++;
      if ({isol_n_a, err_a, done_a, bs_ready_a, ccff_en_a, ccff_head_a, busy_a} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_a: got %b want 0000000",
                  {isol_n_a, err_a, done_a, bs_ready_a, ccff_en_a, ccff_head_a, busy_a});
      end
      n_cmp++;
      if ({isol_n_b, err_b, done_b, bs_ready_b, ccff_en_b, ccff_head_b, busy_b} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_b: got %b want 0000000",
                  {isol_n_b, err_b, done_b, bs_ready_b, ccff_en_b, ccff_head_b, busy_b});
      end
      repeat (3) tick();
      pReset_n = 1'b1;
      tick();
      n_cmp++;
      if ({isol_n_a, busy_a, bs_ready_a} !== 3'b000) begin
         n_bad++;
         $display("FAIL idle_a: isol/busy/ready got %b want 000", {isol_n_a, busy_a, bs_ready_a});
      end
   endtask

   task automatic test_nominal();
      int c0, a1, a2, cd;
      logic iso;
      en_cnt_a = 0;
      start_a = 1'b1;
      c0 = cyc;
      tick();
      start_a = 1'b0;
      n_cmp++;
      if ({busy_a, bs_ready_a, isol_n_a} !== 3'b110) begin
         n_bad++;
         $display("FAIL nom_c1: busy/ready/isol got %b want 110", {busy_a, bs_ready_a, isol_n_a});
      end
      send_a(8'hA5, 8, a1);
      send_a(8'h3C, 4, a2);
      wait_done_a(cd, iso);
      n_cmp++;
      if (a1 - c0 != 1) begin n_bad++; $display("FAIL nom_acc1: got C%0d want C1", a1 - c0); end
      n_cmp++;
      if (a2 - c0 != 9) begin n_bad++; $display("FAIL nom_acc2: got C%0d want C9", a2 - c0); end
      n_cmp++;
      if (en_first_a - c0 != 2 || en_last_a - c0 != 13 || en_cnt_a != 12) begin
         n_bad++;
         $display("FAIL nom_en: got C%0d..C%0d x%0d want C2..C13 x12",
                  en_first_a - c0, en_last_a - c0, en_cnt_a);
      end
      n_cmp++;
      if (cd - c0 != 18) begin n_bad++; $display("FAIL nom_done: got C%0d want C18", cd - c0); end
      n_cmp++;
      if (iso !== 1'b1) begin n_bad++; $display("FAIL nom_isol: got %b want 1", iso); end
      n_cmp++;
      if ({done_a, isol_n_a, busy_a} !== 3'b010) begin
         n_bad++;
         $display("FAIL nom_after: done/isol/busy got %b want 010", {done_a, isol_n_a, busy_a});
      end
      n_cmp++;
      if (q_a.size() != 0) begin n_bad++; $display("FAIL nom_left: got %0d bits want 0", q_a.size()); end
   endtask

   task automatic test_stall();
      int c0, a1, a2, cd;
      logic iso;
      en_cnt_a = 0;
      start_a = 1'b1;
      c0 = cyc;
      tick();
      start_a = 1'b0;
      n_cmp++;
      if ({busy_a, isol_n_a} !== 2'b10) begin
         n_bad++;
         $display("FAIL stall_c1: busy/isol got %b want 10", {busy_a, isol_n_a});
      end
      send_a(8'hA5, 8, a1);
      repeat (12) tick();
      send_a(8'h3C, 4, a2);
      wait_done_a(cd, iso);
      n_cmp++;
      if (a2 - c0 != 14) begin n_bad++; $display("FAIL stall_acc2: got C%0d want C14", a2 - c0); end
      n_cmp++;
      if (cd - c0 != 23) begin n_bad++; $display("FAIL stall_done: got C%0d want C23", cd - c0); end
      n_cmp++;
      if (en_cnt_a != 12 || (en_last_a - en_first_a + 1 - en_cnt_a) != 5) begin
         n_bad++;
         $display("FAIL stall_gap: got %0d pulses gap %0d want 12 gap 5",
                  en_cnt_a, en_last_a - en_first_a + 1 - en_cnt_a);
      end
      n_cmp++;
      if ({err_a, iso} !== 2'b01) begin
         n_bad++;
         $display("FAIL stall_flags: err/isol got %b want 01", {err_a, iso});
      end
   endtask

   task automatic test_timeout();
      int c0, a1, a2, cd;
      logic iso;
      en_cnt_b = 0;
      start_b = 1'b1;
      c0 = cyc;
      tick();
      start_b = 1'b0;
      send_b(8'hA5, 8, a1);
      repeat (10) tick();
      n_cmp++;
      if (err_b !== 1'b0) begin n_bad++; $display("FAIL to_early: err at C12 got %b want 0", err_b); end
      tick();
      n_cmp++;
      if ({err_b, isol_n_b, busy_b, bs_ready_b, ccff_en_b} !== 5'b10000) begin
         n_bad++;
         $display("FAIL to_err: err/isol/busy/ready/en got %b want 10000",
                  {err_b, isol_n_b, busy_b, bs_ready_b, ccff_en_b});
      end
      n_cmp++;
      if (en_cnt_b != 8) begin n_bad++; $display("FAIL to_bits: got %0d want 8", en_cnt_b); end
      repeat (3) tick();
      n_cmp++;
      if (err_b !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", err_b); end
      en_cnt_b = 0;
      start_b = 1'b1;
      c0 = cyc;
      tick();
      start_b = 1'b0;
      n_cmp++;
      if ({err_b, busy_b} !== 2'b01) begin
         n_bad++;
         $display("FAIL to_restart: err/busy got %b want 01", {err_b, busy_b});
      end
      send_b(8'h0F, 8, a1);
      send_b(8'hF0, 8, a2);
      wait_done_b(cd, iso);
      n_cmp++;
      if (cd - c0 != 22 || iso !== 1'b1) begin
         n_bad++;
         $display("FAIL to_reload: done C%0d isol %b want C22 isol 1", cd - c0, iso);
      end
      n_cmp++;
      if (en_cnt_b != 16 || q_b.size() != 0) begin
         n_bad++;
         $display("FAIL to_count: got %0d pulses %0d left want 16 and 0", en_cnt_b, q_b.size());
      end
   endtask

   task automatic test_exact_ignored();
      int c0, a1, a2, cd, hs;
      logic iso;
      en_cnt_b = 0;
      start_b = 1'b1;
      c0 = cyc;
      tick();
      start_b = 1'b0;
      send_b(8'h96, 8, a1);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      send_b(8'h5B, 8, a2);
      bs_data_b = 8'hFF;
      bs_valid_b = 1'b1;
      hs = 0;
      cd = -1;
      iso = 1'bx;
      for (int i = 0; i < 40 && cd < 0; i++) begin
         start_b = (cyc == c0 + 19);
         @(negedge prog_clk);
         if (bs_ready_b && bs_valid_b) hs++;
         if (done_b) begin
            cd = cyc;
            iso = isol_n_b;
         end
         tick();
      end
      start_b = 1'b0;
      bs_valid_b = 1'b0;
      n_cmp++;
      if (a2 - c0 != 9) begin n_bad++; $display("FAIL ex_acc2: got C%0d want C9", a2 - c0); end
      n_cmp++;
      if (hs != 0) begin n_bad++; $display("FAIL ex_extra: got %0d accepts want 0", hs); end
      n_cmp++;
      if (cd - c0 != 22 || iso !== 1'b1) begin
         n_bad++;
         $display("FAIL ex_done: done C%0d isol %b want C22 isol 1", cd - c0, iso);
      end
      n_cmp++;
      if (en_cnt_b != 16 || q_b.size() != 0) begin
         n_bad++;
         $display("FAIL ex_count: got %0d pulses %0d left want 16 and 0", en_cnt_b, q_b.size());
      end
      n_cmp++;
      if ({busy_b, done_b} !== 2'b00) begin
         n_bad++;
         $display("FAIL ex_idle: busy/done got %b want 00", {busy_b, done_b});
      end
   endtask

   task automatic test_reset_midload();
      int c0, a1, a2, cd;
      logic iso;
      en_cnt_a = 0;
      start_a = 1'b1;
      c0 = cyc;
      tick();
      start_a = 1'b0;
      send_a(8'hC3, 8, a1);
      repeat (4) tick();
      pReset_n = 1'b0;
      #1;
      n_cmp++;
      if ({isol_n_a, ccff_en_a, busy_a, bs_ready_a} !== 4'b0000) begin
         n_bad++;
         $display("FAIL rst_async: isol/en/busy/ready got %b want 0000",
                  {isol_n_a, ccff_en_a, busy_a, bs_ready_a});
      end
      n_cmp++;
      if (en_cnt_a != 4) begin n_bad++; $display("FAIL rst_bits: got %0d want 4", en_cnt_a); end
      q_a.delete();
      tick();
      tick();
      pReset_n = 1'b1;
      tick();
      en_cnt_a = 0;
      start_a = 1'b1;
      c0 = cyc;
      tick();
      start_a = 1'b0;
      send_a(8'h3C, 8, a1);
      send_a(8'hA5, 4, a2);
      wait_done_a(cd, iso);
      n_cmp++;
      if (cd - c0 != 18 || iso !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_reload: done C%0d isol %b want C18 isol 1", cd - c0, iso);
      end
      n_cmp++;
      if (en_cnt_a != 12 || q_a.size() != 0) begin
         n_bad++;
         $display("FAIL rst_count: got %0d pulses %0d left want 12 and 0", en_cnt_a, q_a.size());
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_stall();
      test_timeout();
      test_exact_ignored();
      test_reset_midload();
      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule

// File: doc/ccff_bitstream_loader.md
# ccff_bitstream_loader

Configuration-chain loader that sits directly upstream of the first IO tile's `ccff_head` in the fabric's configuration-chain path. It accepts bitstream words over a valid/ready stream and serializes exactly `CHAIN_LEN` bits onto `ccff_head`, MSB first. It drives a per-cycle shift enable so the chain advances only when a real bit is present. It also holds the fabric IOs isolated (`isol_n` low) from reset until programming completes and the chain has settled.

## Interface
- `WORD_W`, default 8: bitstream word width, ≥2.
- `CHAIN_LEN`, default 64: total configuration bits in the chain, ≥1.
- `ISO_HOLD`, default 4: settle cycles after the last bit, before isolation is released; ≥1.
- `TIMEOUT`, default 255: consecutive starved cycles before the loader aborts; ≥1.
- Counter widths are derived by `$clog2` of `CHAIN_LEN+1`, `ISO_HOLD+1`, and `TIMEOUT+1`.

Ports:
- `prog_clk` in 1: the only clock; all state changes on the rising edge.
- `pReset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a load session; sampled only in IDLE or ERR.
- `bs_data` in `WORD_W`: bitstream word; bit `WORD_W-1` is shifted first.
- `bs_valid` in 1: `bs_data` is valid.
- `bs_ready` out 1: the loader accepts `bs_data` this cycle.
- `ccff_head` out 1: serial configuration bit to the chain head.
- `ccff_en` out 1: the chain shifts on this edge (drives the external prog-clock gate).
- `isol_n` out 1: IO isolation, active-low.
- `busy` out 1: the session is in LOAD or HOLD.
- `done` out 1: one-cycle pulse when a session completes.
- `err` out 1: sticky timeout flag.

## Operation
The loader has five states: IDLE, LOAD, HOLD, DONE and ERR.

Internal registers:
- `shreg` (`WORD_W` bits).
- `bit_left`: bits still valid in `shreg`.
- `rem`: chain bits still to shift.
- `hold_cnt` and `stall_cnt` counters.
- The registered `isol_n`.

Behaviour by state:
- **Reset:** state=IDLE; `isol_n`=0, `err`=0, `done`=0, `bs_ready`=0, `ccff_en`=0, `ccff_head`=0, `busy`=0; all counters 0. The fabric stays isolated until the first successful load.
- **IDLE or ERR, with `start`=1:** go to LOAD, with `rem`=`CHAIN_LEN`, `bit_left`=0, `isol_n`=0 and `err` cleared.
- **LOAD, shifting:**
  - When `bit_left`≠0: `ccff_en`=1 and `ccff_head`=`shreg[WORD_W-1]`.
  - On that edge, `shreg` shifts left (zero-fill), and both `bit_left` and `rem` decrement.
  - When `ccff_en`=0: `ccff_head`=0.
- **LOAD, accepting words:**
  - `bs_ready`=1 when `bit_left`≤1 and `rem`>`bit_left`. This gives back-to-back words at 1 bit/cycle, with no bubble.
  - On `bs_valid`&`bs_ready`: `shreg`←`bs_data` and `bit_left`←min(`WORD_W`, `rem`−`bit_left`).
  - Bits of the final word beyond `rem` are dropped and never reach `ccff_head`.
- **LOAD, starvation:**
  - `stall_cnt` increments on each cycle with `bit_left`=0 and `bs_valid`=0.
  - It clears on any accept.
  - When `stall_cnt` reaches `TIMEOUT`, go to ERR.
- **LOAD to HOLD:** on the edge where `rem` becomes 0. `bs_ready`=0 from then on.
- **HOLD:** `ccff_en`=0 for `ISO_HOLD` cycles, then go to DONE.
- **DONE:** lasts one cycle with `done`=1. `isol_n` rises to 1 on entry to DONE and stays 1 until the next `start`. Then go to IDLE.
- **ERR:**
  - `err`=1 (sticky), `isol_n` held at 0, `busy`=0, `bs_ready`=0, `ccff_en`=0.
  - Leaves only on `start` or reset.
  - A partially loaded chain is never un-isolated.
- **`start` in LOAD, HOLD or DONE:** ignored.
- **Reset mid-session:** returns to IDLE with `isol_n`=0 immediately (asynchronously); the chain contents are undefined and a full reload is required.

## Timing
- Let C0 be the `start` cycle in IDLE. LOAD begins at C1, with `busy`=1 and `bs_ready`=1 from C1.
- First word accepted at cycle Ca: `ccff_en` is high from Ca+1.
- The chain receives exactly `CHAIN_LEN` `ccff_en` pulses per session. They are contiguous if `bs_valid` never drops.
- Last `ccff_en` at cycle Cl: HOLD covers Cl+1 … Cl+`ISO_HOLD`; `done` and `isol_n`=1 occur at Cl+`ISO_HOLD`+1.
- Minimum session length is `CHAIN_LEN`+`ISO_HOLD`+3 cycles from `start`.
- `ccff_head` and `ccff_en` are decoded directly from registers, with no input-to-output combinational path. `bs_ready` depends only on registers.

## Test plan
- **Nominal load.** Setup: `WORD_W`=8, `CHAIN_LEN`=12, `ISO_HOLD`=4. Stimulus: `start` at C0, then words 0xA5 and 0x3C with `bs_valid` held high. Required response:
  - `ccff_head` sequence 1,0,1,0,0,1,0,1,0,0,1,1 on 12 contiguous `ccff_en` cycles C2–C13.
  - Second word accepted at C9; the low nibble (1100) of 0x3C is dropped.
  - `done` pulse and `isol_n`↑ at C18.
- **Stall.** Stimulus: drop `bs_valid` for 5 cycles between words. Required response: `ccff_en` low for exactly those cycles, the bit order is unchanged, `err`=0, and `done` is delayed by 5.
- **Timeout.** Stimulus: `TIMEOUT`=3; after the first word, `bs_valid`=0. Required response: the first word finishes shifting, then ERR after 3 starved cycles; `err`=1, `isol_n`=0, `busy`=0. A subsequent `start` clears `err` and a full reload completes normally.
- **Reset mid-load.** Stimulus: assert `pReset_n`=0 at C6. Required response: `isol_n`, `ccff_en`, `busy` and `bs_ready` are 0 asynchronously. After release, the next `start` shifts a full `CHAIN_LEN` bits.
- **Ignored start and exact-multiple length.** Stimulus: pulse `start` during LOAD and during HOLD. Required response: no effect, and the bit count stays `CHAIN_LEN`. With `CHAIN_LEN`=16, exactly two words are accepted and `bs_ready` is 0 after the second.
